// File: rtl/parammod_pkg.sv
// parammod_pkg: shared FSM state type and index-width helper for lane-addressing blocks
package parammod_pkg;

    typedef enum logic {IDLE, SEND} ser_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_serializer_lane_sel.sv
// lane_sel: combinational pick of one DATA-wide lane out of a packed vector
module lane_sel #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int IW = 2
) (
    input  logic [N-1:0][W-1:0] i_vec,
    input  logic [IW-1:0]       i_idx,
    output logic [W-1:0]        o_data
);

    // Compare against every legal lane so out-of-range indices (non-power-of-2 N) give zero
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++)
            if (i_idx == IW'(i))
                o_data = i_vec[i];
    end

endmodule

// File: rtl/vec_serializer.sv
// vec_serializer: expands one packed IN x DATA vector into IN word-serial beats
module vec_serializer
    import parammod_pkg::*;
#(
    parameter int IN        = 4,
    parameter int DATA      = 16,
    parameter bit LSB_FIRST = 1'b1,
    parameter int IDX       = idx_w(IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN-1:0][DATA-1:0]  in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA-1:0]          out_data,
    output logic [IDX-1:0]           out_idx,
    output logic                     out_last
);

    localparam logic [IDX-1:0] LAST = IDX'(IN - 1);

    ser_state_t              r_state, w_next;
    logic [IN-1:0][DATA-1:0] r_buf, w_vec;
    logic [IDX-1:0]          r_cnt, w_cnt_nxt, w_lane;
    logic [DATA-1:0]         r_data, w_sel;
    logic                    w_load, w_adv;

    assign w_load    = in_valid & in_ready;
    assign w_adv     = out_valid & out_ready & ~out_last;
    assign w_vec     = w_load ? in : r_buf;
    assign w_cnt_nxt = w_load ? '0 : r_cnt + 1'b1;
    assign w_lane    = LSB_FIRST ? w_cnt_nxt : LAST - w_cnt_nxt;
    assign out_data  = r_data;

    lane_sel #(.N(IN), .W(DATA), .IW(IDX)) u_sel (
        .i_vec  (w_vec),
        .i_idx  (w_lane),
        .o_data (w_sel)
    );

    // State register
    always_ff @(posedge clk)
        r_state <= reset ? IDLE : w_next;

    // Next state: a last-word transfer without a new vector returns to IDLE
    always_comb
        w_next = (r_state == IDLE) ? (w_load ? SEND : IDLE)
                                   : ((out_ready & out_last & ~w_load) ? IDLE : SEND);

    // Outputs: in_ready opens only when the last word leaves, never looks at in_valid
    always_comb begin
        out_valid = (r_state == SEND);
        out_last  = out_valid & (r_cnt == LAST);
        out_idx   = out_valid ? (LSB_FIRST ? r_cnt : LAST - r_cnt) : '0;
        in_ready  = ~reset & (~out_valid | (out_last & out_ready));
    end

    // Datapath: load a fresh vector at lane counter 0, or step to the next lane on transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_buf  <= in;
            r_cnt  <= '0;
            r_data <= w_sel;
        end else if (w_adv) begin
            r_cnt  <= w_cnt_nxt;
            r_data <= w_sel;
        end
    end

endmodule

// File: tb/tb_vec_serializer.sv
// tb_vec_serializer: table-driven cycle checks plus scoreboard for vec_serializer
module tb_vec_serializer;

    typedef struct {
        bit          iv;
        int          vs;
        bit          ordy;
        bit          ov;
        bit          ir;
        logic [15:0] d;
        logic [1:0]  i;
        bit          l;
    } row_t;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  i;
        bit          l;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic iv = 1'b0, ordy = 1'b0;
    logic [3:0][15:0] vin = '0;
    logic ir, ov, ol;
    logic [15:0] od;
    logic [1:0] oi;

    logic iv3 = 1'b0, ordy3 = 1'b1;
    logic [2:0][15:0] vin3 = '0;
    logic ir3, ov3, ol3;
    logic [15:0] od3;
    logic [1:0] oi3;

    int n_cmp = 0, n_err = 0, n_acc = 0;
    exp_t q[$];
    row_t tbl[$];
    logic [3:0][15:0] bank [3];
    bit prev_stall = 1'b0;
    logic [18:0] prev_word;

    always #5 clk = ~clk;

    vec_serializer #(.IN(4), .DATA(16), .LSB_FIRST(1'b1)) u4 (
        .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in(vin),
        .out_valid(ov), .out_ready(ordy), .out_data(od), .out_idx(oi), .out_last(ol)
    );

    vec_serializer #(.IN(3), .DATA(16), .LSB_FIRST(1'b0)) u3 (
        .clk(clk), .reset(reset), .in_valid(iv3), .in_ready(ir3), .in(vin3),
        .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_idx(oi3), .out_last(ol3)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: push lanes on accept, pop on each output transfer; also check stall stability
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            if (prev_stall)
                chk("stall_hold", {ov, od, oi, ol}, {1'b1, prev_word});
            if (ov && ordy) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", {od, oi, ol}, 64'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_word", {od, oi, ol}, {e.d, e.i, e.l});
                end
            end
            if (iv && ir) begin
                n_acc++;
                for (int l = 0; l < 4; l++)
                    q.push_back(exp_t'{vin[l], 2'(l), l == 3});
            end
        end
        prev_stall = !reset && ov && !ordy;
        prev_word  = {od, oi, ol};
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, guard, seen;
        bank[0] = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        bank[1] = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        bank[2] = {16'h0014, 16'h0013, 16'h0012, 16'h0011};
        // single vector, LSB first
        tbl.push_back(row_t'{1, 0, 1, 0, 1, 16'h0000, 0, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hAAAA, 0, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hBBBB, 1, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hCCCC, 2, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 1, 16'hDDDD, 3, 1});
        tbl.push_back(row_t'{0, 0, 1, 0, 1, 16'hDDDD, 0, 0});
        // back-to-back vectors, no bubble
        tbl.push_back(row_t'{1, 1, 1, 0, 1, 16'hDDDD, 0, 0});
        tbl.push_back(row_t'{1, 2, 1, 1, 0, 16'h0001, 0, 0});
        tbl.push_back(row_t'{1, 2, 1, 1, 0, 16'h0002, 1, 0});
        tbl.push_back(row_t'{1, 2, 1, 1, 0, 16'h0003, 2, 0});
        tbl.push_back(row_t'{1, 2, 1, 1, 1, 16'h0004, 3, 1});
        tbl.push_back(row_t'{0, 2, 1, 1, 0, 16'h0011, 0, 0});
        tbl.push_back(row_t'{0, 2, 1, 1, 0, 16'h0012, 1, 0});
        tbl.push_back(row_t'{0, 2, 1, 1, 0, 16'h0013, 2, 0});
        tbl.push_back(row_t'{0, 2, 1, 1, 1, 16'h0014, 3, 1});
        tbl.push_back(row_t'{0, 2, 1, 0, 1, 16'h0014, 0, 0});
        // backpressure 1,0,0,1,0,1,1 with an ignored in_valid while stalled
        tbl.push_back(row_t'{1, 0, 1, 0, 1, 16'h0014, 0, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hAAAA, 0, 0});
        tbl.push_back(row_t'{0, 0, 0, 1, 0, 16'hBBBB, 1, 0});
        tbl.push_back(row_t'{1, 1, 0, 1, 0, 16'hBBBB, 1, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hBBBB, 1, 0});
        tbl.push_back(row_t'{0, 0, 0, 1, 0, 16'hCCCC, 2, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 16'hCCCC, 2, 0});
        tbl.push_back(row_t'{0, 0, 1, 1, 1, 16'hDDDD, 3, 1});
        tbl.push_back(row_t'{0, 0, 1, 0, 1, 16'hDDDD, 0, 0});

        // reset
        @(negedge clk);
        chk("reset_in_ready", ir, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_values", {ov, od, oi, ol, ir}, {1'b0, 16'h0, 2'd0, 1'b0, 1'b1});
        @(posedge clk); #1;

        // table-driven cycle checks
        foreach (tbl[k]) begin
            iv = tbl[k].iv;
            vin = bank[tbl[k].vs];
            ordy = tbl[k].ordy;
            @(negedge clk);
            chk($sformatf("row%0d", k), {ov, ir, od, oi, ol},
                {tbl[k].ov, tbl[k].ir, tbl[k].d, tbl[k].i, tbl[k].l});
            @(posedge clk); #1;
        end
        iv = 1'b0;

        // IN=3, MSB first
        vin3 = {16'h3333, 16'h2222, 16'h1111};
        iv3 = 1'b1;
        @(negedge clk);
        chk("in3_accept", ir3, 1);
        @(posedge clk); #1;
        iv3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("in3_word%0d", k), {ov3, od3, oi3, ol3},
                {1'b1, vin3[2-k], 2'(2-k), k == 2});
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("in3_idle", {ov3, ol3}, 0);
        @(posedge clk); #1;

        // reset after the second word
        iv = 1'b1; vin = bank[0]; ordy = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; iv = 1'b1; vin = bank[1];
        @(negedge clk);
        chk("midrst_in_ready", ir, 0);
        @(posedge clk); #1;
        reset = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("midrst_out", {ov, od, oi, ol}, 0);
        @(posedge clk); #1;
        iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        @(negedge clk);
        chk("midrst_restart", {ov, od, oi, ol}, {1'b1, 16'h0001, 2'd0, 1'b0});
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_drained", q.size(), 0);

        // random regression
        base = n_acc; seen = n_acc; guard = 0;
        while (n_acc - base < 100 && guard < 4000) begin
            if (n_acc != seen) begin
                seen = n_acc;
                iv = 1'b0;
            end
            if (!iv && $urandom_range(0, 2) != 0) begin
                for (int l = 0; l < 4; l++) vin[l] = 16'($urandom);
                iv = 1'b1;
            end
            ordy = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
            guard++;
        end
        iv = 1'b0; ordy = 1'b1;
        guard = 0;
        while ((q.size() != 0 || ov) && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rand_accepted", n_acc - base, 100);
        chk("rand_drained", {q.size(), ov}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vec_serializer.md
Name: vec_serializer

Overview:
- Sequential counterpart of the lane-reduction path: the reducer collapses IN lanes into one word; this block expands one packed IN x DATA vector into a stream of IN single-DATA words.
- Sits between wide parallel producers (e.g. register banks, vector units) and narrow word-serial consumers.
- Uses valid/ready handshakes on both sides.
- Sustains one output word per cycle with back-to-back vectors; no bubble between vectors.

Parameters:
- IN, 4: lane count per vector; legal range IN >= 2.
- DATA, 16: lane width in bits.
- LSB_FIRST, `ENABLE: `ENABLE emits lane 0 first; `DISABLE emits lane IN-1 first.
- IDX, $clog2(IN): lane index width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  packed vector on `in` is valid.
- in_ready  output  1  block accepts a vector this cycle.
- in  input  [IN-1:0][DATA-1:0]  packed input vector.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  DATA  current lane word; registered.
- out_idx  output  IDX  lane number of out_data, in original lane numbering.
- out_last  output  1  high with the final word of a vector.

Behaviour:
- Interface:
  - One clock, `clk`.
  - Reset `reset` is synchronous and active-high.
  - While `reset` is high: `in_ready` is forced to 0; input is ignored.
- Reset values, on the first edge with `reset` high:
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - state=IDLE, counter=0, holding buffer=0.
- Transfer rules:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- State IDLE:
  - in_ready=1.
  - On input transfer: latch the full vector into the holding buffer and go to SEND.
  - Next cycle: out_valid=1, showing the first lane (lane 0 if LSB_FIRST, else lane IN-1).
  - Latency from input transfer to first out_valid is 1 cycle.
- State SEND:
  - out_valid=1.
  - out_data, out_idx and out_last are held stable while out_ready=0 (no change while stalled).
  - On output transfer of a non-last word: advance to the next lane. Order is ascending if LSB_FIRST, else descending.
  - out_last=1 exactly when the counter has reached IN-1 words sent.
- in_ready in SEND:
  - Combinational: out_last & out_ready.
  - Never depends on in_valid (no combinational loop).
- Last word transferred together with an input transfer:
  - Load the new vector.
  - Remain in SEND and present its first lane next cycle.
  - Result is zero bubble: IN cycles per vector at full throughput.
- Last word transferred with no input transfer:
  - Go to IDLE; out_valid=0 next cycle.
  - out_data holds its last value (don't-care for consumers, but must not be X).
- in_valid=1 in SEND while in_ready=0: no effect; the producer must hold its data.
- Reset mid-vector:
  - Remaining words are discarded.
  - out_valid=0 on the next cycle; no partial resumption.
- Counter:
  - IDX bits wide.
  - Never wraps past IN-1; it is reloaded to 0 on each vector load.
  - Must be correct for non-power-of-2 IN (e.g. IN=3, IDX=2, count 0..2).
- out_idx:
  - LSB_FIRST: equals the counter.
  - Otherwise: equals IN-1-counter.
- No arithmetic on data; lanes are passed through bit-exact.

Decomposition:
- Shared package `parammod_pkg`:
  - typedef `ser_state_t` (enum IDLE, SEND).
  - Localparam helper for index width: max(1, $clog2(IN)).
- Sub-module `lane_sel`:
  - Purely combinational.
  - Selects a DATA word from the packed vector given an index.
  - Reusable by other lane-addressing blocks.
- Everything else stays in one module.

Test Plan:
1. Reset then single vector, DATA=16, IN=4, LSB_FIRST:
   - Stimulus: in={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, out_ready=1.
   - Required: words AAAA,BBBB,CCCC,DDDD with idx 0..3 on 4 consecutive cycles, starting 1 cycle after accept; out_last only with DDDD; out_valid=0 afterwards.
2. Back-to-back vectors:
   - Stimulus: in_valid held 1 with two vectors, 0x0001..0x0004 then 0x0011..0x0014; out_ready=1.
   - Required: 8 words on 8 consecutive cycles with no bubble; in_ready pulses exactly on the two last-word cycles.
3. Backpressure:
   - Stimulus: out_ready toggled 1,0,0,1,0,1,1.
   - Required: out_data/out_idx unchanged on every cycle with out_ready=0; all 4 words delivered exactly once, in order; in_ready=0 throughout SEND until the last transfer.
4. LSB_FIRST=`DISABLE`, IN=3:
   - Stimulus: in={16'h3333,16'h2222,16'h1111}.
   - Required: 3333/idx2, 2222/idx1, 1111/idx0 in that order, last on 1111.
5. Reset mid-vector:
   - Stimulus: assert reset after the 2nd word.
   - Required: out_valid=0 from the next cycle; next vector restarts at lane 0 with no stale words.
6. Random regression:
   - Stimulus: 100 random vectors (`$random`) with random out_ready and in_valid.
   - Required: scoreboard shows every lane emitted exactly once, in order, with correct idx/last.
